// File: rtl/fragment_test_pkg.sv
// Shared definitions for the multi-lane fragment test stage: compare codes,
// colour channel positions, depth clamp and compare helpers.
package fragment_test_pkg;

  typedef enum logic [2:0] {
    CMP_ALWAYS   = 3'd0,
    CMP_NEVER    = 3'd1,
    CMP_LESS     = 3'd2,
    CMP_EQUAL    = 3'd3,
    CMP_LEQUAL   = 3'd4,
    CMP_GREATER  = 3'd5,
    CMP_NOTEQUAL = 3'd6,
    CMP_GEQUAL   = 3'd7
  } cmpFunc_t;

  // Channel slot inside a colour word; alpha occupies the top bits.
  localparam int CH_R         = 0;
  localparam int CH_G         = 1;
  localparam int CH_B         = 2;
  localparam int CH_A         = 3;
  localparam int NUM_CHANNELS = 4;

  // Negative depths go to zero, anything at or above 1.0 saturates to all ones.
  function automatic logic [31:0] clampDepth(input logic [31:0] depth, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    if (depth[31]) begin
      return 32'd0;
    end
    if ((depth & ~maxVal) != 32'd0) begin
      return maxVal;
    end
    return depth;
  endfunction

  function automatic logic compareFunc(input logic [2:0] func, input logic [31:0] a, input logic [31:0] b);
    logic result;
    result = 1'b0;
    case (cmpFunc_t'(func))
      CMP_ALWAYS:   result = 1'b1;
      CMP_NEVER:    result = 1'b0;
      CMP_LESS:     result = (a < b);
      CMP_EQUAL:    result = (a == b);
      CMP_LEQUAL:   result = (a <= b);
      CMP_GREATER:  result = (a > b);
      CMP_NOTEQUAL: result = (a != b);
      CMP_GEQUAL:   result = (a >= b);
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/fragment_test_lane.sv
// One fragment lane: depth clamp, alpha and depth tests feeding S1, plus the
// per-channel colour merge that feeds S2. Purely combinational.
module fragment_test_lane
  import fragment_test_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int DEPTH_WIDTH     = 16
) (
  input  logic                                  i_keep,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] i_color,
  input  logic [31:0]                           i_depth,
  input  logic [DEPTH_WIDTH-1:0]                i_fbDepth,
  input  logic                                  i_depthTestEnable,
  input  logic [2:0]                            i_depthFunc,
  input  logic                                  i_alphaTestEnable,
  input  logic [2:0]                            i_alphaFunc,
  input  logic [SUB_PIXEL_WIDTH-1:0]            i_alphaRef,
  output logic                                  o_pass,
  output logic [DEPTH_WIDTH-1:0]                o_clampedDepth,
  input  logic [3:0]                            i_colorMask,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] i_mergeFragColor,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] i_mergeFbColor,
  output logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] o_mergedColor
);

  logic [31:0]                w_clamped;
  logic [SUB_PIXEL_WIDTH-1:0] w_alpha;
  logic                       w_alphaPass;
  logic                       w_depthPass;

  always_comb begin
    w_clamped      = clampDepth(i_depth, DEPTH_WIDTH);
    w_alpha        = i_color[CH_A*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
    w_alphaPass    = !i_alphaTestEnable || compareFunc(i_alphaFunc, 32'(w_alpha), 32'(i_alphaRef));
    w_depthPass    = !i_depthTestEnable || compareFunc(i_depthFunc, w_clamped, 32'(i_fbDepth));
    o_pass         = i_keep && w_alphaPass && w_depthPass;
    o_clampedDepth = i_keep ? w_clamped[DEPTH_WIDTH-1:0] : '0;
  end

  // Mask bit 3 selects red, bit 0 alpha, so channel c uses bit (3 - c).
  always_comb begin
    o_mergedColor = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      o_mergedColor[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH] = i_colorMask[NUM_CHANNELS-1-c]
        ? i_mergeFragColor[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH]
        : i_mergeFbColor[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
    end
  end

endmodule

// File: rtl/fragment_test_lanes.sv
// Multi-lane fragment test stage with a two-register AXI-Stream pipeline.
// Define FRAGMENT_TEST_STATS_EN to add the statProcessed/statPassed counters.
module fragment_test_lanes
  import fragment_test_pkg::*;
#(
  parameter int LANES           = 2,
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int DEPTH_WIDTH     = 16,
  parameter int INDEX_WIDTH     = 14
) (
  input  logic                                          aclk,
  input  logic                                          reset,
  input  logic                                          confDepthTestEnable,
  input  logic [2:0]                                    confDepthFunc,
  input  logic                                          confAlphaTestEnable,
  input  logic [2:0]                                    confAlphaFunc,
  input  logic [SUB_PIXEL_WIDTH-1:0]                    confAlphaRef,
  input  logic [3:0]                                    confColorMask,
  input  logic                                          confDepthMask,
  input  logic                                          s_frag_tvalid,
  output logic                                          s_frag_tready,
  input  logic                                          s_frag_tlast,
  input  logic [LANES-1:0]                              s_frag_tkeep,
  input  logic [LANES*INDEX_WIDTH-1:0]                  s_frag_tindex,
  input  logic [LANES*NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] s_frag_tcolor,
  input  logic [LANES*32-1:0]                           s_frag_tdepth,
  input  logic [LANES*NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] s_frag_color_tdata,
  input  logic [LANES*DEPTH_WIDTH-1:0]                  s_frag_depth_tdata,
  output logic                                          m_frag_tvalid,
  input  logic                                          m_frag_tready,
  output logic                                          m_frag_tlast,
  output logic [LANES*INDEX_WIDTH-1:0]                  m_frag_taddr,
  output logic [LANES*NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] m_frag_color_tdata,
  output logic [LANES-1:0]                              m_frag_color_tstrb,
  output logic [LANES*DEPTH_WIDTH-1:0]                  m_frag_depth_tdata,
  output logic [LANES-1:0]                              m_frag_depth_tstrb,
  output logic                                          fragmentProcessed
`ifdef FRAGMENT_TEST_STATS_EN
  ,
  output logic [31:0]                                   statProcessed,
  output logic [31:0]                                   statPassed
`endif
);

  localparam int CW = NUM_CHANNELS * SUB_PIXEL_WIDTH;

  logic                         w_ce;
  logic                         w_s1Load;
  logic [LANES-1:0]             w_pass;
  logic [LANES*DEPTH_WIDTH-1:0] w_clampedDepth;
  logic [LANES*INDEX_WIDTH-1:0] w_keptIndex;
  logic [LANES*CW-1:0]          w_keptColor;
  logic [LANES*CW-1:0]          w_keptFbColor;
  logic [LANES*CW-1:0]          w_mergedColor;

  logic                         r_s1Valid;
  logic                         r_s1Last;
  logic [LANES-1:0]             r_s1Pass;
  logic [LANES*INDEX_WIDTH-1:0] r_s1Addr;
  logic [LANES*CW-1:0]          r_s1Color;
  logic [LANES*CW-1:0]          r_s1FbColor;
  logic [LANES*DEPTH_WIDTH-1:0] r_s1Depth;
  logic [3:0]                   r_s1ColorMask;
  logic                         r_s1DepthWrite;

  logic                         r_s2Valid;
  logic                         r_s2Last;
  logic [LANES*INDEX_WIDTH-1:0] r_s2Addr;
  logic [LANES*CW-1:0]          r_s2Color;
  logic [LANES-1:0]             r_s2ColorStrb;
  logic [LANES*DEPTH_WIDTH-1:0] r_s2Depth;
  logic [LANES-1:0]             r_s2DepthStrb;

  // S1 may refill a bubble even while S2 is stalled downstream.
  assign w_ce          = !r_s2Valid || m_frag_tready;
  assign w_s1Load      = !r_s1Valid || w_ce;
  assign s_frag_tready = w_s1Load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_keptIndex[i*INDEX_WIDTH +: INDEX_WIDTH] = s_frag_tkeep[i] ? s_frag_tindex[i*INDEX_WIDTH +: INDEX_WIDTH] : '0;
    assign w_keptColor[i*CW +: CW]   = s_frag_tkeep[i] ? s_frag_tcolor[i*CW +: CW] : '0;
    assign w_keptFbColor[i*CW +: CW] = s_frag_tkeep[i] ? s_frag_color_tdata[i*CW +: CW] : '0;

    fragment_test_lane #(
      .SUB_PIXEL_WIDTH(SUB_PIXEL_WIDTH),
      .DEPTH_WIDTH    (DEPTH_WIDTH)
    ) u_lane (
      .i_keep           (s_frag_tkeep[i]),
      .i_color          (s_frag_tcolor[i*CW +: CW]),
      .i_depth          (s_frag_tdepth[i*32 +: 32]),
      .i_fbDepth        (s_frag_depth_tdata[i*DEPTH_WIDTH +: DEPTH_WIDTH]),
      .i_depthTestEnable(confDepthTestEnable),
      .i_depthFunc      (confDepthFunc),
      .i_alphaTestEnable(confAlphaTestEnable),
      .i_alphaFunc      (confAlphaFunc),
      .i_alphaRef       (confAlphaRef),
      .o_pass           (w_pass[i]),
      .o_clampedDepth   (w_clampedDepth[i*DEPTH_WIDTH +: DEPTH_WIDTH]),
      .i_colorMask      (r_s1ColorMask),
      .i_mergeFragColor (r_s1Color[i*CW +: CW]),
      .i_mergeFbColor   (r_s1FbColor[i*CW +: CW]),
      .o_mergedColor    (w_mergedColor[i*CW +: CW])
    );
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_s1Valid      <= 1'b0;
      r_s1Last       <= 1'b0;
      r_s1Pass       <= '0;
      r_s1Addr       <= '0;
      r_s1Color      <= '0;
      r_s1FbColor    <= '0;
      r_s1Depth      <= '0;
      r_s1ColorMask  <= '0;
      r_s1DepthWrite <= 1'b0;
    end else if (w_s1Load) begin
      r_s1Valid      <= s_frag_tvalid;
      r_s1Last       <= s_frag_tlast;
      r_s1Pass       <= w_pass;
      r_s1Addr       <= w_keptIndex;
      r_s1Color      <= w_keptColor;
      r_s1FbColor    <= w_keptFbColor;
      r_s1Depth      <= w_clampedDepth;
      r_s1ColorMask  <= confColorMask;
      r_s1DepthWrite <= confDepthMask && confDepthTestEnable;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_s2Valid     <= 1'b0;
      r_s2Last      <= 1'b0;
      r_s2Addr      <= '0;
      r_s2Color     <= '0;
      r_s2ColorStrb <= '0;
      r_s2Depth     <= '0;
      r_s2DepthStrb <= '0;
    end else if (w_ce) begin
      r_s2Valid     <= r_s1Valid;
      r_s2Last      <= r_s1Valid && r_s1Last;
      r_s2Addr      <= r_s1Addr;
      r_s2Color     <= w_mergedColor;
      r_s2ColorStrb <= r_s1Pass & {LANES{r_s1Valid && (|r_s1ColorMask)}};
      r_s2Depth     <= r_s1Depth;
      r_s2DepthStrb <= r_s1Pass & {LANES{r_s1Valid && r_s1DepthWrite}};
    end
  end

  assign m_frag_tvalid      = r_s2Valid;
  assign m_frag_tlast       = r_s2Last;
  assign m_frag_taddr       = r_s2Addr;
  assign m_frag_color_tdata = r_s2Color;
  assign m_frag_color_tstrb = r_s2ColorStrb;
  assign m_frag_depth_tdata = r_s2Depth;
  assign m_frag_depth_tstrb = r_s2DepthStrb;
  assign fragmentProcessed  = r_s2Valid && m_frag_tready;

`ifdef FRAGMENT_TEST_STATS_EN
  logic [LANES-1:0] r_s1Keep;
  logic [LANES-1:0] r_s2Keep;
  logic [LANES-1:0] r_s2Pass;

  // Keep and pass masks follow the beat so the counters see what leaves S2.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_s1Keep      <= '0;
      r_s2Keep      <= '0;
      r_s2Pass      <= '0;
      statProcessed <= '0;
      statPassed    <= '0;
    end else begin
      if (w_s1Load) begin
        r_s1Keep <= s_frag_tkeep;
      end
      if (w_ce) begin
        r_s2Keep <= r_s1Keep;
        r_s2Pass <= r_s1Pass;
      end
      if (fragmentProcessed) begin
        statProcessed <= statProcessed + 32'($countones(r_s2Keep));
        statPassed    <= statPassed + 32'($countones(r_s2Pass));
      end
    end
  end
`endif

endmodule
